adc_trig_window: RTL and testbench



---
 rtl/adc_trig_window.sv | 161 ++++++++++++++++
 tb/tb_adc_trig_window.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/adc_trig_window.sv
// adc_trig_window: trigger-driven ADC capture sequencer in the clk2 domain.
// An accepted trigger starts a programmable delay, followed by a window of
// cfg_nsamp samples framed with valid/last, and then a holdoff period before
// the block re-arms. Accepted and missed triggers are both counted.
module adc_trig_window #(
  parameter int DW      = 12,
  parameter int CW      = 10,
  parameter int TCW     = 16,
  parameter int HOLDOFF = 4
) (
  input  logic           clk2,
  input  logic           rstb,
  input  logic           trig,
  input  logic           enable,
  input  logic           abort,
  input  logic [CW-1:0]  cfg_delay,
  input  logic [CW-1:0]  cfg_nsamp,
  input  logic [DW-1:0]  adc_data,
  output logic [DW-1:0]  out_data,
  output logic           out_valid,
  output logic           out_last,
  output logic           busy,
  output logic [TCW-1:0] trig_cnt,
  output logic [TCW-1:0] miss_cnt
);

  // The holdoff counter must be able to hold the value HOLDOFF itself.
  localparam int HW = (HOLDOFF < 2) ? 1 : $clog2(HOLDOFF + 1);

  // After a real window the cycle that presents the last sample is spent in
  // HOLDOFF as well, so the counter starts at HOLDOFF and runs down to 0.
  // A zero-sample window has no last sample, so one cycle less is loaded.
  localparam logic [HW-1:0] HOLD_AFTER_LAST = HW'(HOLDOFF);
  localparam logic [HW-1:0] HOLD_NO_SAMPLES = HW'(HOLDOFF - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_CAPTURE,
    S_HOLDOFF
  } state_t;

  state_t          state_q,    state_d;
  logic [CW-1:0]   dly_cnt_q,  dly_cnt_d;
  logic [CW-1:0]   samp_cnt_q, samp_cnt_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic            out_last_q, out_last_d;
  logic            busy_q,     busy_d;
  logic [TCW-1:0]  trig_cnt_q, trig_cnt_d;
  logic [TCW-1:0]  miss_cnt_q, miss_cnt_d;

  // Next-state, counters and framing outputs; abort overrides everything.
  always_comb begin
    state_d     = state_q;
    dly_cnt_d   = dly_cnt_q;
    samp_cnt_d  = samp_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    trig_cnt_d  = trig_cnt_q;
    miss_cnt_d  = miss_cnt_q;

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      if (trig && enable && (state_q != S_IDLE) && !(&miss_cnt_q)) begin
        miss_cnt_d = miss_cnt_q + TCW'(1);
      end

      case (state_q)
        S_IDLE: begin
          if (trig && enable) begin
            trig_cnt_d = trig_cnt_q + TCW'(1);
            samp_cnt_d = cfg_nsamp;
            if (cfg_nsamp == '0) begin
              state_d    = S_HOLDOFF;
              hold_cnt_d = HOLD_NO_SAMPLES;
            end else if (cfg_delay == '0) begin
              state_d = S_CAPTURE;
            end else begin
              state_d   = S_DELAY;
              dly_cnt_d = cfg_delay - CW'(1);
            end
          end
        end

        S_DELAY: begin
          if (dly_cnt_q == '0) begin
            state_d = S_CAPTURE;
          end else begin
            dly_cnt_d = dly_cnt_q - CW'(1);
          end
        end

        S_CAPTURE: begin
          out_data_d  = adc_data;
          out_valid_d = 1'b1;
          if (samp_cnt_q == CW'(1)) begin
            out_last_d = 1'b1;
            state_d    = S_HOLDOFF;
            hold_cnt_d = HOLD_AFTER_LAST;
          end else begin
            samp_cnt_d = samp_cnt_q - CW'(1);
          end
        end

        S_HOLDOFF: begin
          if (hold_cnt_q == '0) begin
            state_d = S_IDLE;
          end else begin
            hold_cnt_d = hold_cnt_q - HW'(1);
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk2 or negedge rstb) begin
    if (!rstb) begin
      state_q     <= S_IDLE;
      dly_cnt_q   <= '0;
      samp_cnt_q  <= '0;
      hold_cnt_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      trig_cnt_q  <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      dly_cnt_q   <= dly_cnt_d;
      samp_cnt_q  <= samp_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      trig_cnt_q  <= trig_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign trig_cnt  = trig_cnt_q;
  assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_adc_trig_window.sv
// tb_adc_trig_window: directed and randomized stimulus for adc_trig_window,
// compared every cycle against a window-timing reference model.
module tb_adc_trig_window;

  localparam int DW  = 12;
  localparam int CW  = 10;
  localparam int TCW = 4;
  localparam int HO  = 4;

  logic           clk2 = 1'b0;
  logic           rstb;
  logic           trig;
  logic           enable;
  logic           abort;
  logic [CW-1:0]  cfg_delay;
  logic [CW-1:0]  cfg_nsamp;
  logic [DW-1:0]  adc_data;
  logic [DW-1:0]  out_data;
  logic           out_valid;
  logic           out_last;
  logic           busy;
  logic [TCW-1:0] trig_cnt;
  logic [TCW-1:0] miss_cnt;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: absolute cycle numbers of the current window.
  int             cyc = 0;
  int             idle_at = 0;
  int             vstart = 0;
  int             vend = -1;
  logic [DW-1:0]  exp_data = '0;
  logic [TCW-1:0] exp_trig = '0;
  logic [TCW-1:0] exp_miss = '0;
  logic [DW-1:0]  adc_hist [0:8191];
  bit             use_ramp = 1'b0;

  adc_trig_window #(
    .DW(DW), .CW(CW), .TCW(TCW), .HOLDOFF(HO)
  ) dut (
    .clk2(clk2), .rstb(rstb), .trig(trig), .enable(enable), .abort(abort),
    .cfg_delay(cfg_delay), .cfg_nsamp(cfg_nsamp), .adc_data(adc_data),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .busy(busy), .trig_cnt(trig_cnt), .miss_cnt(miss_cnt)
  );

  // 10 ns capture clock, rising edges at 5, 15, 25, ...
  always #5 clk2 = ~clk2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic modelReset();
    idle_at  = 0;
    vstart   = 0;
    vend     = -1;
    exp_data = '0;
    exp_trig = '0;
    exp_miss = '0;
  endtask

  task automatic checkOutput();
    bit ev;
    bit el;
    ev = (cyc >= vstart) && (cyc <= vend);
    el = ev && (cyc == vend);
    if (ev) exp_data = adc_hist[cyc-1];
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("out_last",  32'(out_last),  32'(el));
    chk("out_data",  32'(out_data),  32'(exp_data));
    chk("busy",      32'(busy),      32'(cyc < idle_at));
    chk("trig_cnt",  32'(trig_cnt),  32'(exp_trig));
    chk("miss_cnt",  32'(miss_cnt),  32'(exp_miss));
  endtask

  // Drive this cycle's inputs and advance the model across the closing edge.
  task automatic applyStimulus(input logic t, input logic e, input logic a,
                               input int d, input int n);
    bit idle;
    trig      = t;
    enable    = e;
    abort     = a;
    cfg_delay = CW'(d);
    cfg_nsamp = CW'(n);
    adc_data  = use_ramp ? DW'(cyc * 3 + 1) : DW'($urandom());
    adc_hist[cyc] = adc_data;
    idle = (cyc >= idle_at);
    if (a) begin
      if (vend > cyc) vend = cyc;
      if (!idle) idle_at = cyc + 1;
    end else if (t && e) begin
      if (idle) begin
        exp_trig = exp_trig + 1'b1;
        if (n == 0) begin
          idle_at = cyc + 1 + HO;
        end else begin
          vstart  = cyc + 2 + d;
          vend    = cyc + 1 + d + n;
          idle_at = vend + HO + 1;
        end
      end else if (exp_miss != '1) begin
        exp_miss = exp_miss + 1'b1;
      end
    end
  endtask

  task automatic step(input logic t, input logic e, input logic a, input int d, input int n);
    @(posedge clk2);
    #1;
    cyc++;
    checkOutput();
    applyStimulus(t, e, a, d, n);
  endtask

  initial begin
    rstb = 1'b1;
    trig = 1'b0; enable = 1'b0; abort = 1'b0;
    cfg_delay = '0; cfg_nsamp = '0; adc_data = '0;
    #1 rstb = 1'b0;
    #11;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_data",  32'(out_data),  32'd0);
    #10 rstb = 1'b1;

    // Triggers with enable low are ignored entirely.
    for (int i = 0; i < 8; i++) step(i[0], 1'b0, 1'b0, 2, 3);

    // Delay 3, five samples of a ramp.
    use_ramp = 1'b1;
    step(1'b1, 1'b1, 1'b0, 3, 5);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 3, 5);
    use_ramp = 1'b0;

    // Single sample, no delay; trigger every cycle to probe the re-arm edge.
    step(1'b1, 1'b1, 1'b0, 0, 1);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 0, 1);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b0, 0, 1);

    // One miss during capture and one during holdoff.
    step(1'b1, 1'b1, 1'b0, 2, 6);
    for (int i = 1; i < 20; i++) step((i == 5) || (i == 12), 1'b1, 1'b0, 2, 6);

    // Config changes during delay do not affect the latched window.
    step(1'b1, 1'b1, 1'b0, 4, 5);
    for (int i = 0; i < 18; i++) step(1'b0, 1'b1, 1'b0, 0, 8);

    // Zero-sample window: counted, no data, holdoff only.
    step(1'b1, 1'b1, 1'b0, 3, 0);
    for (int i = 0; i < 8; i++) step(i == 6, 1'b1, 1'b0, 3, 0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 3, 0);

    // Abort on the third sample of a ten-sample window, with a trig alongside.
    step(1'b1, 1'b1, 1'b0, 1, 10);
    for (int i = 1; i < 12; i++) step(i == 5, 1'b1, i == 5, 1, 10);

    // Enable dropped mid-window still lets the window finish.
    step(1'b1, 1'b1, 1'b0, 1, 4);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0, 1, 4);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 5) == 0, $urandom_range(0, 4) != 0,
           $urandom_range(0, 40) == 0,
           int'($urandom_range(0, 5)), int'($urandom_range(0, 7)));
    end
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b0, 0, 1);

    // Long window with a trigger every cycle drives miss_cnt into saturation.
    step(1'b1, 1'b1, 1'b0, 0, 40);
    for (int i = 0; i < 48; i++) step(1'b1, 1'b1, 1'b0, 0, 40);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 0, 40);

    // Reset asserted in the middle of a capture clears every output at once.
    step(1'b1, 1'b1, 1'b0, 0, 10);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 0, 10);
    @(posedge clk2);
    #1;
    cyc++;
    checkOutput();
    trig = 1'b0; enable = 1'b0; abort = 1'b0;
    adc_hist[cyc] = adc_data;
    rstb = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_last",  32'(out_last),  32'd0);
    chk("mid_rst_data",  32'(out_data),  32'd0);
    chk("mid_rst_busy",  32'(busy),      32'd0);
    chk("mid_rst_trig",  32'(trig_cnt),  32'd0);
    chk("mid_rst_miss",  32'(miss_cnt),  32'd0);
    modelReset();
    #2 rstb = 1'b1;

    // Recovery after reset.
    step(1'b1, 1'b1, 1'b0, 1, 3);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b0, 1, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
